// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - framebuffer arbiter: display line prefetch into ping-pong buffers plus writer port
// Optional underrun counter output when VGA_FB_UNDERRUN_EN is defined.
module vga_fb_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_out
`ifdef VGA_FB_UNDERRUN_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [9:0]        drawy_q, drawy_d;
  logic [1:0]        bank_valid_q, bank_valid_d;
  logic [9:0]        fetch_line_q, fetch_line_d;
  logic [9:0]        fetch_x_q, fetch_x_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic [9:0]        mem_x_q, mem_x_d;
  logic              mem_bank_q, mem_bank_d;
  logic              pend_q, pend_d;
  logic [9:0]        pend_x_q, pend_x_d;
  logic              pend_bank_q, pend_bank_d;
  logic [DATA_W-1:0] pix_q, pix_d;

  logic [DATA_W-1:0] linebuf [2][H_ACTIVE];

  logic              line_start;
  logic [9:0]        next_line;
  logic              fetch_go;

  function automatic logic [ADDR_W-1:0] line_base(input logic [9:0] line);
    return ADDR_W'(line) * ADDR_W'(H_ACTIVE);
  endfunction

  always_comb begin
    line_start = (DrawY != drawy_q);
    next_line  = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    fetch_go   = line_start && (next_line < 10'(V_ACTIVE));
  end

  always_comb begin
    state_d      = state_q;
    drawy_d      = DrawY;
    bank_valid_d = bank_valid_q;
    fetch_line_d = fetch_line_q;
    fetch_x_d    = fetch_x_q;
    mem_addr_d   = mem_addr_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    wr_gnt_d     = 1'b0;
    mem_x_d      = mem_x_q;
    mem_bank_d   = mem_bank_q;
    // Read data returns the cycle after mem_re; carry its x/bank tag one more stage.
    pend_d       = mem_re_q;
    pend_x_d     = mem_x_q;
    pend_bank_d  = mem_bank_q;

    if (fetch_go) begin
      // New line always wins; any fetch in flight is abandoned and its return dropped.
      bank_valid_d[next_line[0]] = 1'b0;
      fetch_line_d = next_line;
      fetch_x_d    = 10'd1;
      mem_re_d     = 1'b1;
      mem_addr_d   = line_base(next_line);
      mem_x_d      = 10'd0;
      mem_bank_d   = next_line[0];
      pend_d       = 1'b0;
      state_d      = FETCH;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_req && !wr_gnt_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            wr_gnt_d    = 1'b1;
          end
        end
        FETCH: begin
          if (line_start) begin
            pend_d  = 1'b0;
            state_d = IDLE;
          end else begin
            mem_re_d   = 1'b1;
            mem_addr_d = line_base(fetch_line_q) + ADDR_W'(fetch_x_q);
            mem_x_d    = fetch_x_q;
            mem_bank_d = fetch_line_q[0];
            fetch_x_d  = fetch_x_q + 10'd1;
            if (fetch_x_q == 10'(H_ACTIVE - 1)) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (line_start) begin
            pend_d = 1'b0;
          end else begin
            bank_valid_d[fetch_line_q[0]] = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pix_d = '0;
    if (DrawX < 10'(H_ACTIVE) && DrawY < 10'(V_ACTIVE) && bank_valid_q[DrawY[0]])
      pix_d = linebuf[DrawY[0]][DrawX];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      drawy_q      <= 10'(V_TOTAL - 1);
      bank_valid_q <= '0;
      fetch_line_q <= '0;
      fetch_x_q    <= '0;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      wr_gnt_q     <= 1'b0;
      mem_x_q      <= '0;
      mem_bank_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_x_q     <= '0;
      pend_bank_q  <= 1'b0;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      drawy_q      <= drawy_d;
      bank_valid_q <= bank_valid_d;
      fetch_line_q <= fetch_line_d;
      fetch_x_q    <= fetch_x_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_gnt_q     <= wr_gnt_d;
      mem_x_q      <= mem_x_d;
      mem_bank_q   <= mem_bank_d;
      pend_q       <= pend_d;
      pend_x_q     <= pend_x_d;
      pend_bank_q  <= pend_bank_d;
      pix_q        <= pix_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_q) linebuf[pend_bank_q][pend_x_q] <= mem_rdata;
  end

  assign wr_gnt    = wr_gnt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign pix_out   = pix_q;

`ifdef VGA_FB_UNDERRUN_EN
  logic [15:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (line_start && DrawY < 10'(V_ACTIVE) && !bank_valid_q[DrawY[0]] && underrun_q != 16'hFFFF)
      underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) underrun_q <= '0;
    else       underrun_q <= underrun_d;
  end

  assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb/tb_vga_fb_scheduler.sv - scoreboard bench for vga_fb_scheduler
module tb_vga_fb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_gnt;
  logic [18:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pix_out;
`ifdef VGA_FB_UNDERRUN_EN
  logic [15:0] underrun_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [18:0] exp_rd [$];
  logic [18:0] exp_wa [$];
  logic [7:0]  exp_wd [$];
  logic [7:0]  exp_pix [$];

  logic [7:0]  mem [0:524287];

  vga_fb_scheduler dut (
    .clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_out(pix_out)
`ifdef VGA_FB_UNDERRUN_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_re || mem_we) check("re_we_exclusive", 32'(mem_re && mem_we), 32'd0);
      if (mem_re) begin
        check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) check("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
      end
      if (mem_we || wr_gnt) begin
        check("gnt_with_we", 32'(wr_gnt), 32'(mem_we));
        check("wr_expected", 32'(exp_wa.size() != 0), 32'd1);
        if (exp_wa.size() != 0) begin
          check("wr_addr", 32'(mem_addr), 32'(exp_wa.pop_front()));
          check("wr_data", 32'(mem_wdata), 32'(exp_wd.pop_front()));
        end
      end
      if (exp_pix.size() != 0) check("pix_out", 32'(pix_out), 32'(exp_pix.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic push_line(input int line);
    for (int x = 0; x < 640; x++) exp_rd.push_back(19'(line * 640 + x));
  endtask

  task automatic set_y(input int y);
    int nl;
    tick();
    if (10'(y) != DrawY) begin
      exp_rd.delete();
      nl = (y == 524) ? 0 : y + 1;
      if (nl < 480) push_line(nl);
    end
    DrawY = 10'(y);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (exp_rd.size() != 0 && n < 2000) begin tick(); n++; end
    check("fetch_done_in_time", 32'(exp_rd.size() == 0), 32'd1);
    tick(); tick();
  endtask

  task automatic chk_pix(input int x, input logic [7:0] e);
    DrawX = 10'(x);
    exp_pix.push_back(e);
    tick();
  endtask

  task automatic do_write(input logic [18:0] a, input logic [7:0] d, output int waited);
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    exp_wa.push_back(a); exp_wd.push_back(d);
    waited = 0;
    do begin @(negedge clk); waited++; end while (!wr_gnt && waited < 2000);
    check("wr_gnt_in_time", 32'(wr_gnt), 32'd1);
    #1 wr_req = 1'b0;
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    for (int i = 0; i < 524288; i++) mem[i] = 8'(i);
    reset = 1'b1; DrawX = '0; DrawY = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
    check("rst_pix_out", 32'(pix_out), 32'd0);
    #1;
    push_line(1);
    reset = 1'b0;
    @(negedge clk);
    check("first_rd_re", 32'(mem_re), 32'd1);
    check("first_rd_addr", 32'(mem_addr), 32'd640);
    #1;
    wait_fetch();
`ifdef VGA_FB_UNDERRUN_EN
    check("underrun_after_reset", 32'(underrun_cnt), 32'd1);
`endif
    chk_pix(3, 8'h00);

    do_write(19'd1234, 8'hAB, w);
    check("wr_lat_idle", 32'(w), 32'd1);
    set_y(1);
    chk_pix(594, 8'hD2);
    wait_fetch();
    set_y(0);
    do_write(19'd100, 8'h11, w);
    check("wr_lat_fetch_wins", 32'(w), 32'd642);
    wait_fetch();
    set_y(1);
    chk_pix(594, 8'hAB);
    wait_fetch();

    set_y(2);
    tick();
    do_write(19'd5000, 8'h5A, w);
    check("wr_lat_during_fetch", 32'(w), 32'd641);
    wait_fetch();

    set_y(4);
    wait_fetch();
    set_y(5);
    chk_pix(3, 8'h83);
    chk_pix(700, 8'h00);
    chk_pix(639, 8'hFF);
    wait_fetch();

    set_y(478);
    wait_fetch();
    set_y(479);
    do_write(19'd2000, 8'h33, w);
    check("wr_lat_no_fetch", 32'(w), 32'd1);
    repeat (5) tick();
    set_y(523);
    tick();
    set_y(524);
    wait_fetch();
    set_y(0);
    chk_pix(10, 8'h0A);
    chk_pix(100, 8'h11);
    wait_fetch();

    set_y(10);
    repeat (100) tick();
    set_y(20);
    @(negedge clk);
    check("abort_restart_addr", 32'(mem_addr), 32'd13440);
    #1;
    repeat (50) tick();
    set_y(11);
    chk_pix(5, 8'h00);
    wait_fetch();
    chk_pix(5, 8'h00);

    set_y(13);
    repeat (20) tick();
    reset = 1'b1;
    DrawY = '0;
    exp_rd.delete();
    @(negedge clk);
    check("rst_mid_mem_re", 32'(mem_re), 32'd0);
    check("rst_mid_pix", 32'(pix_out), 32'd0);
    #1;
    push_line(1);
    reset = 1'b0;
    wait_fetch();
    chk_pix(5, 8'h00);
    set_y(1);
    chk_pix(2, 8'h82);
    wait_fetch();

    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_wa.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
